// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed scanner for a multi-digit 7-segment display.
// Captures a packed BCD value into a shadow buffer and promotes it to the
// displayed (active) buffer only at frame boundaries, so a frame never tears.
// Each digit is lit for SCAN_DIV cycles; outputs are registered and computed
// from next-state values so they change on the same edge as index/active.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module seven_seg_scan #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 50000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      load,
    input  logic                      enable,
    output logic [3:0]                bcd_out,
    output logic                      dp_out,
    output logic [NUM_DIGITS-1:0]     digit_sel,
    output logic                      frame_done
);

    localparam int unsigned DATA_W = 4 * NUM_DIGITS;
    localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
    localparam int unsigned PS_W   = $clog2(SCAN_DIV);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PS_W-1:0]  LAST_PS  = PS_W'(SCAN_DIV - 1);
    localparam logic [3:0]       BLANK    = 4'hF;

    // Scan position
    logic [PS_W-1:0]       prescaler_q, prescaler_d;
    logic [IDX_W-1:0]      index_q,     index_d;

    // Double-buffered display data
    logic [DATA_W-1:0]     shadow_data_q, shadow_data_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q,   shadow_dp_d;
    logic [DATA_W-1:0]     active_data_q, active_data_d;
    logic [NUM_DIGITS-1:0] active_dp_q,   active_dp_d;
    logic                  pending_q,     pending_d;

    // Registered outputs
    logic [NUM_DIGITS-1:0] digit_sel_q,  digit_sel_d;
    logic [3:0]            bcd_q,        bcd_d;
    logic                  dp_q,         dp_d;
    logic                  frame_done_q, frame_done_d;

    // Scan strobes
    logic                  tick_c;
    logic                  wrap_c;

    // Per-digit display selection helpers
    logic [NUM_DIGITS-1:0] lz_blank_c;
    logic [3:0]            sel_nib_c;
    logic                  sel_dp_c;
    logic                  sel_blank_c;

    // Digit advance happens on the last prescaler count; frame wraps on the last digit
    assign tick_c = enable && (prescaler_q == LAST_PS);
    assign wrap_c = tick_c && (index_q == LAST_IDX);

    // Next-state for scan counters and the shadow/active buffers
    always_comb begin
        prescaler_d   = prescaler_q;
        index_d       = index_q;
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        active_data_d = active_data_q;
        active_dp_d   = active_dp_q;
        pending_d     = pending_q;

        if (enable) begin
            prescaler_d = tick_c ? '0 : prescaler_q + PS_W'(1);
        end

        if (tick_c) begin
            index_d = (index_q == LAST_IDX) ? '0 : index_q + IDX_W'(1);
        end

        // Loads are always accepted into the shadow, even while blanked
        if (load) begin
            shadow_data_d = digits_in;
            shadow_dp_d   = dp_in;
            pending_d     = 1'b1;
        end

        // Promote new data only at the frame boundary; a same-cycle load wins
        if (wrap_c) begin
            if (load) begin
                active_data_d = digits_in;
                active_dp_d   = dp_in;
            end else if (pending_q) begin
                active_data_d = shadow_data_q;
                active_dp_d   = shadow_dp_q;
            end
            pending_d = 1'b0;
        end
    end

    // Leading-zero mask over the next active data; digit 0 is never blanked
    always_comb begin
        lz_blank_c = '0;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic lz_run;
            lz_run = 1'b1;
            for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
                if (lz_run && (active_data_d[4*i +: 4] == 4'h0) && !active_dp_d[i]) begin
                    lz_blank_c[i] = 1'b1;
                end else begin
                    lz_run = 1'b0;
                end
            end
        end
`endif
    end

    // Pick the nibble, dp and blank flag for the next digit index
    always_comb begin
        sel_nib_c   = BLANK;
        sel_dp_c    = 1'b0;
        sel_blank_c = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (index_d == IDX_W'(i)) begin
                sel_nib_c   = active_data_d[4*i +: 4];
                sel_dp_c    = active_dp_d[i];
                sel_blank_c = lz_blank_c[i];
            end
        end
    end

    // Output next-state: blanked while disabled, otherwise the selected digit
    always_comb begin
        digit_sel_d  = '0;
        bcd_d        = BLANK;
        dp_d         = 1'b0;
        frame_done_d = wrap_c;

        if (enable) begin
            digit_sel_d = NUM_DIGITS'(1) << index_d;
            bcd_d       = sel_blank_c ? BLANK : sel_nib_c;
            dp_d        = sel_dp_c;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler_q   <= '0;
            index_q       <= '0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            active_data_q <= '0;
            active_dp_q   <= '0;
            pending_q     <= 1'b0;
            digit_sel_q   <= '0;
            bcd_q         <= BLANK;
            dp_q          <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            prescaler_q   <= prescaler_d;
            index_q       <= index_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            active_data_q <= active_data_d;
            active_dp_q   <= active_dp_d;
            pending_q     <= pending_d;
            digit_sel_q   <= digit_sel_d;
            bcd_q         <= bcd_d;
            dp_q          <= dp_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign digit_sel  = digit_sel_q;
    assign bcd_out    = bcd_q;
    assign dp_out     = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with NUM_DIGITS=4, SCAN_DIV=4.
// Honours LEADING_ZERO_BLANK_EN when selecting expected blanking values.
module tb_seven_seg_scan;

    localparam int unsigned ND = 4;
    localparam int unsigned SD = 4;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [3:0] LZ = 4'hF;
`else
    localparam logic [3:0] LZ = 4'h0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   digits_in;
    logic [3:0]    dp_in;
    logic          load;
    logic          enable;
    logic [3:0]    bcd_out;
    logic          dp_out;
    logic [3:0]    digit_sel;
    logic          frame_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seven_seg_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
        .clk        (clk),
        .rst        (rst),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .load       (load),
        .enable     (enable),
        .bcd_out    (bcd_out),
        .dp_out     (dp_out),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    // Advance one clock; outputs are observed 1 time unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] nib(input logic [15:0] d, input int i);
        logic [15:0] t;
        t = d >> (4 * i);
        return t[3:0];
    endfunction

    function automatic logic [3:0] onehot(input int i);
        logic [3:0] r;
        r = 4'b0001 << i;
        return r;
    endfunction

    // Bounded wait for a frame_done pulse
    task automatic wait_frame(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            cyc();
            if (frame_done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            n_cmp++; if (digit_sel !== 4'b0000) begin n_err++; $display("FAIL reset_sel c=%0d got %b exp 0000", c, digit_sel); end
            n_cmp++; if (bcd_out !== 4'hF) begin n_err++; $display("FAIL reset_bcd c=%0d got %h exp f", c, bcd_out); end
            n_cmp++; if (dp_out !== 1'b0) begin n_err++; $display("FAIL reset_dp c=%0d got %b exp 0", c, dp_out); end
            n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_fd c=%0d got %b exp 0", c, frame_done); end
        end
        rst = 1'b0;
    endtask

    task automatic test_scan_order();
        bit seen;
        digits_in = 16'h1234; dp_in = 4'b0100; load = 1'b1;
        cyc();
        load = 1'b0;
        n_cmp++; if (digit_sel !== 4'b0001) begin n_err++; $display("FAIL first_sel got %b exp 0001", digit_sel); end
        n_cmp++; if (bcd_out !== 4'h0) begin n_err++; $display("FAIL first_bcd got %h exp 0", bcd_out); end
        wait_frame(seen);
        n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL scan_wait_frame got %b exp 1", seen); end
        for (int p = 0; p < 16; p++) begin
            n_cmp++; if (digit_sel !== onehot(p / 4)) begin n_err++; $display("FAIL scan_sel p=%0d got %b exp %b", p, digit_sel, onehot(p / 4)); end
            n_cmp++; if (bcd_out !== nib(16'h1234, p / 4)) begin n_err++; $display("FAIL scan_bcd p=%0d got %h exp %h", p, bcd_out, nib(16'h1234, p / 4)); end
            n_cmp++; if (dp_out !== ((p / 4) == 2)) begin n_err++; $display("FAIL scan_dp p=%0d got %b exp %b", p, dp_out, (p / 4) == 2); end
            n_cmp++; if (frame_done !== (p == 0)) begin n_err++; $display("FAIL scan_fd p=%0d got %b exp %b", p, frame_done, p == 0); end
            cyc();
        end
        n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL scan_period got %b exp 1", frame_done); end
        n_cmp++; if (digit_sel !== 4'b0001) begin n_err++; $display("FAIL scan_wrap_sel got %b exp 0001", digit_sel); end
    endtask

    task automatic test_tear_free();
        repeat (4) cyc();
        digits_in = 16'h5678; dp_in = 4'b0000; load = 1'b1;
        cyc();
        load = 1'b0;
        for (int p = 5; p < 16; p++) begin
            n_cmp++; if (digit_sel !== onehot(p / 4)) begin n_err++; $display("FAIL tear_sel p=%0d got %b exp %b", p, digit_sel, onehot(p / 4)); end
            n_cmp++; if (bcd_out !== nib(16'h1234, p / 4)) begin n_err++; $display("FAIL tear_old p=%0d got %h exp %h", p, bcd_out, nib(16'h1234, p / 4)); end
            cyc();
        end
        for (int p = 0; p < 16; p++) begin
            n_cmp++; if (bcd_out !== nib(16'h5678, p / 4)) begin n_err++; $display("FAIL tear_new p=%0d got %h exp %h", p, bcd_out, nib(16'h5678, p / 4)); end
            n_cmp++; if (dp_out !== 1'b0) begin n_err++; $display("FAIL tear_dp p=%0d got %b exp 0", p, dp_out); end
            n_cmp++; if (frame_done !== (p == 0)) begin n_err++; $display("FAIL tear_fd p=%0d got %b exp %b", p, frame_done, p == 0); end
            cyc();
        end
    endtask

    task automatic test_load_on_wrap();
        repeat (15) cyc();
        digits_in = 16'h9012; dp_in = 4'b0000; load = 1'b1;
        cyc();
        load = 1'b0;
        n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL wrapload_fd got %b exp 1", frame_done); end
        n_cmp++; if (digit_sel !== 4'b0001) begin n_err++; $display("FAIL wrapload_sel got %b exp 0001", digit_sel); end
        n_cmp++; if (bcd_out !== 4'h2) begin n_err++; $display("FAIL wrapload_bcd got %h exp 2", bcd_out); end
        n_cmp++; if (dut.pending_q !== 1'b0) begin n_err++; $display("FAIL wrapload_pending got %b exp 0", dut.pending_q); end
    endtask

    // Starts at frame position 0 of the 9012 frame; also loads 0045 while blanked
    task automatic test_enable_gap();
        repeat (8) cyc();
        cyc();
        n_cmp++; if (digit_sel !== 4'b0100) begin n_err++; $display("FAIL gap_pre_sel got %b exp 0100", digit_sel); end
        enable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin digits_in = 16'h0045; dp_in = 4'b0000; load = 1'b1; end
            cyc();
            load = 1'b0;
            n_cmp++; if (digit_sel !== 4'b0000) begin n_err++; $display("FAIL gap_sel c=%0d got %b exp 0000", c, digit_sel); end
            n_cmp++; if (bcd_out !== 4'hF) begin n_err++; $display("FAIL gap_bcd c=%0d got %h exp f", c, bcd_out); end
            n_cmp++; if (dp_out !== 1'b0) begin n_err++; $display("FAIL gap_dp c=%0d got %b exp 0", c, dp_out); end
            n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL gap_fd c=%0d got %b exp 0", c, frame_done); end
        end
        enable = 1'b1;
        for (int c = 0; c < 2; c++) begin
            cyc();
            n_cmp++; if (digit_sel !== 4'b0100) begin n_err++; $display("FAIL gap_resume_sel c=%0d got %b exp 0100", c, digit_sel); end
            n_cmp++; if (bcd_out !== 4'h0) begin n_err++; $display("FAIL gap_resume_bcd c=%0d got %h exp 0", c, bcd_out); end
        end
        cyc();
        n_cmp++; if (digit_sel !== 4'b1000) begin n_err++; $display("FAIL gap_next_sel got %b exp 1000", digit_sel); end
        n_cmp++; if (bcd_out !== 4'h9) begin n_err++; $display("FAIL gap_next_bcd got %h exp 9", bcd_out); end
        repeat (4) cyc();
        n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL gap_wrap_fd got %b exp 1", frame_done); end
    endtask

    // Starts at frame position 0 of the 0045 frame
    task automatic test_blanking();
        logic [15:0] exp_v;
        exp_v = {LZ, LZ, 4'h4, 4'h5};
        for (int p = 0; p < 16; p++) begin
            n_cmp++; if (digit_sel !== onehot(p / 4)) begin n_err++; $display("FAIL blank45_sel p=%0d got %b exp %b", p, digit_sel, onehot(p / 4)); end
            n_cmp++; if (bcd_out !== nib(exp_v, p / 4)) begin n_err++; $display("FAIL blank45_bcd p=%0d got %h exp %h", p, bcd_out, nib(exp_v, p / 4)); end
            cyc();
        end
        digits_in = 16'h0000; dp_in = 4'b0000; load = 1'b1;
        cyc();
        load = 1'b0;
        repeat (15) cyc();
        exp_v = {LZ, LZ, LZ, 4'h0};
        for (int p = 0; p < 16; p++) begin
            n_cmp++; if (bcd_out !== nib(exp_v, p / 4)) begin n_err++; $display("FAIL blank0_bcd p=%0d got %h exp %h", p, bcd_out, nib(exp_v, p / 4)); end
            cyc();
        end
        digits_in = 16'h0000; dp_in = 4'b0100; load = 1'b1;
        cyc();
        load = 1'b0;
        repeat (15) cyc();
        exp_v = {LZ, 4'h0, 4'h0, 4'h0};
        for (int p = 0; p < 16; p++) begin
            n_cmp++; if (bcd_out !== nib(exp_v, p / 4)) begin n_err++; $display("FAIL blankdp_bcd p=%0d got %h exp %h", p, bcd_out, nib(exp_v, p / 4)); end
            n_cmp++; if (dp_out !== ((p / 4) == 2)) begin n_err++; $display("FAIL blankdp_dp p=%0d got %b exp %b", p, dp_out, (p / 4) == 2); end
            cyc();
        end
    endtask

    // Two loads in one frame: the later one is displayed; non-BCD passes through
    task automatic test_back_to_back();
        digits_in = 16'h00A1; dp_in = 4'b0000; load = 1'b1;
        cyc();
        load = 1'b0;
        repeat (5) cyc();
        digits_in = 16'h00B2; load = 1'b1;
        cyc();
        load = 1'b0;
        repeat (9) cyc();
        n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL b2b_fd got %b exp 1", frame_done); end
        n_cmp++; if (bcd_out !== 4'h2) begin n_err++; $display("FAIL b2b_d0 got %h exp 2", bcd_out); end
        repeat (4) cyc();
        n_cmp++; if (digit_sel !== 4'b0010) begin n_err++; $display("FAIL b2b_sel got %b exp 0010", digit_sel); end
        n_cmp++; if (bcd_out !== 4'hB) begin n_err++; $display("FAIL b2b_d1 got %h exp b", bcd_out); end
    endtask

    // Reset with a load pending must discard it
    task automatic test_reset_mid();
        bit seen;
        digits_in = 16'h1111; dp_in = 4'b1111; load = 1'b1;
        cyc();
        load = 1'b0;
        rst = 1'b1;
        cyc();
        n_cmp++; if (digit_sel !== 4'b0000) begin n_err++; $display("FAIL rstmid_sel got %b exp 0000", digit_sel); end
        n_cmp++; if (bcd_out !== 4'hF) begin n_err++; $display("FAIL rstmid_bcd got %h exp f", bcd_out); end
        n_cmp++; if (dut.pending_q !== 1'b0) begin n_err++; $display("FAIL rstmid_pending got %b exp 0", dut.pending_q); end
        rst = 1'b0;
        cyc();
        n_cmp++; if (digit_sel !== 4'b0001) begin n_err++; $display("FAIL rstmid_first_sel got %b exp 0001", digit_sel); end
        wait_frame(seen);
        n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL rstmid_wait_frame got %b exp 1", seen); end
        n_cmp++; if (bcd_out !== 4'h0) begin n_err++; $display("FAIL rstmid_d0 got %h exp 0", bcd_out); end
        n_cmp++; if (dp_out !== 1'b0) begin n_err++; $display("FAIL rstmid_dp got %b exp 0", dp_out); end
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_tear_free();
        test_load_on_wrap();
        test_enable_gap();
        test_blanking();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
